pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 4: number of register stages; SHALL be at least 1.
REQ-003 Parameter NOP_VAL, default 0: payload value held by empty or flushed stages.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst_n_i, input, 1 bit: reset; synchronous, active-low.
REQ-006 Port in_valid_i, input, 1 bit: upstream has a word on in_data_i.
REQ-007 Port in_ready_o, output, 1 bit: block accepts the word this cycle.
REQ-008 Port in_data_i, input, WIDTH bits: upstream payload.
REQ-009 Port out_valid_o, output, 1 bit: the oldest word is on out_data_o.
REQ-010 Port out_ready_i, input, 1 bit: downstream consumes the word this cycle.
REQ-011 Port out_data_o, output, WIDTH bits: payload of the oldest stage.
REQ-012 Port flush_i, input, 1 bit: kill all in-flight words (branch/exception squash).
REQ-013 Port occupancy_o, output, $clog2(DEPTH+2) bits: number of valid words held.

Function
REQ-014 Stage 0 is nearest the input and stage DEPTH-1 nearest the output; each stage holds one valid bit and one payload.
REQ-015 Transfer rules:
- A transfer at the input SHALL occur when in_valid_i and in_ready_o are both high.
- A transfer at the output SHALL occur when out_valid_o and out_ready_i are both high.
REQ-016 Stage advance: stage k SHALL pass its word to stage k+1 when stage k+1 is empty or is itself advancing in the same cycle; stage DEPTH-1 SHALL advance on an output transfer.
REQ-017 Bubble collapse: an empty stage SHALL be filled by the stage before it whenever that stage is valid, so bubbles collapse under backpressure.
REQ-018 out_valid_o SHALL equal the valid bit of stage DEPTH-1, and out_data_o SHALL equal its payload.
REQ-019 Latency: a word accepted at edge N into an empty chain SHALL appear on out_valid_o after edge N+DEPTH-1.
REQ-020 Throughput: with out_ready_i held high, the block SHALL accept and deliver one word per cycle.
REQ-021 Stability: while out_valid_o is high and out_ready_i is low, out_data_o SHALL NOT change.
REQ-022 Ordering: words SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 Empty stages: a stage whose valid bit is low SHALL hold NOP_VAL.
REQ-024 Flush high at an edge:
- all valid bits SHALL be cleared and every payload set to NOP_VAL;
- any input transfer in that cycle SHALL be discarded;
- flush_i SHALL take priority over all other events.
REQ-025 An output transfer in the same cycle as flush_i SHALL still complete, because downstream has already sampled it.
REQ-026 occupancy_o SHALL be registered, SHALL equal the count of valid words after each edge, and SHALL never exceed the configured capacity.

Reset
REQ-027 While rst_n_i is low at a rising edge, all valid bits SHALL be cleared, all payloads set to NOP_VAL, and occupancy_o set to 0.
REQ-028 in_ready_o SHALL be forced low for as long as rst_n_i is low.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight words with no partial output.

Configuration
REQ-030 Macro PIPE_SKID_BUFFER_EN defined:
- a one-entry skid register SHALL sit ahead of stage 0;
- in_ready_o SHALL be driven directly from a flop (high exactly when the skid entry is empty), with no combinational path from out_ready_i;
- an accepted word that stage 0 cannot take SHALL be parked in the skid entry and SHALL enter stage 0 before any newer word;
- capacity SHALL be DEPTH+1;
- flush_i and reset SHALL also clear the skid entry.
REQ-031 Macro PIPE_SKID_BUFFER_EN not defined:
- no skid register SHALL exist;
- in_ready_o SHALL be high when stage 0 is empty or advancing (combinational from out_ready_i);
- capacity SHALL be DEPTH.

Structure
REQ-032 Shared package pipe_pkg SHALL hold:
- the default NOP_VAL constant;
- the occupancy-width function.
REQ-033 Sub-module pipe_stage SHALL implement one valid+payload register with load, hold and clear controls, instantiated DEPTH times via generate.

Verification
REQ-034 Streaming: DEPTH=4, no skid, out_ready_i high, send 0x11..0x18 on consecutive cycles -> 0x11 appears 3 cycles after its acceptance edge, then one word per cycle in order; occupancy_o settles at 4.
REQ-035 Backpressure: fill 4 words, hold out_ready_i low for 10 cycles -> in_ready_o low, out_data_o stable at the first word; release -> all 4 words drain in order.
REQ-036 Bubble collapse: send 0xA1, idle 2 cycles, send 0xA2, with out_ready_i low -> both words sit in stages 3 and 2 with occupancy_o=2; release -> back-to-back delivery.
REQ-037 Flush: 3 words in flight, pulse flush_i together with in_valid_i=1 carrying 0xFF -> next cycle out_valid_o=0, occupancy_o=0, out_data_o=NOP_VAL, and 0xFF never appears.
REQ-038 Skid: PIPE_SKID_BUFFER_EN defined, DEPTH=2, out_ready_i low, send 3 words -> all 3 accepted, occupancy_o=3, in_ready_o low; release -> order preserved.
REQ-039 Reset mid-stream: drive rst_n_i low for 1 cycle with 2 words held -> in_ready_o low during reset, then all outputs at reset values, and neither word is ever delivered.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_reg_chain slice.
//   NOP_VAL_DEFAULT : payload held by empty or flushed stages unless overridden
//   occ_width()     : bit width of the occupancy counter for a given depth.
//                     It is sized for DEPTH+1 so that the optional skid entry
//                     (PIPE_SKID_BUFFER_EN) always fits.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned NOP_VAL_DEFAULT = 0;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One pipeline slot: a valid bit plus a payload register.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : synchronous active-low reset (slot becomes empty, payload NOP_VAL)
//   load_i   : capture data_i and mark the slot valid
//   clear_i  : empty the slot (payload NOP_VAL); wins over load_i
//   data_i   : payload to capture on load
//   valid_o  : slot holds a word
//   data_o   : slot payload
// With neither load_i nor clear_i the slot holds its contents.
// -----------------------------------------------------------------------------
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(NOP_VAL_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = NOP_VAL;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
// Valid/ready register chain of DEPTH stages with bubble collapse and flush.
// Stage 0 is nearest the input, stage DEPTH-1 drives the output.
// Ports:
//   clk_i        : clock, rising edge
//   rst_n_i      : synchronous active-low reset
//   in_valid_i   : upstream word present on in_data_i
//   in_ready_o   : word accepted this cycle (low while in reset)
//   in_data_i    : upstream payload
//   out_valid_o  : oldest word present on out_data_o
//   out_ready_i  : downstream takes the word this cycle
//   out_data_o   : payload of stage DEPTH-1 (NOP_VAL when empty)
//   flush_i      : squash every in-flight word; an output transfer in the
//                  same cycle still counts as delivered
//   occupancy_o  : registered count of valid words held
// Build option:
//   PIPE_SKID_BUFFER_EN : adds a one-entry skid register ahead of stage 0 so
//                         in_ready_o comes from a flop instead of out_ready_i;
//                         capacity becomes DEPTH+1.
// -----------------------------------------------------------------------------
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(NOP_VAL_DEFAULT)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic                         flush_i,
  output logic [occ_width(DEPTH)-1:0]  occupancy_o
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] stage_in   [DEPTH];
  logic [DEPTH-1:0] stage_load;
  logic [DEPTH-1:0] stage_clear;
  // vacate[k]: the word in stage k moves on (to k+1 or out) at this edge.
  logic [DEPTH-1:0] vacate;

  logic             in_fire;
  logic             out_fire;
  logic             stage0_free;
  logic             stage0_fill;
  logic [WIDTH-1:0] stage0_src;

  logic [OCC_W-1:0] occ_d, occ_q;

  assign out_valid_o = stage_valid[DEPTH-1];
  assign out_data_o  = stage_data[DEPTH-1];
  assign out_fire    = out_valid_o & out_ready_i;
  assign in_fire     = in_valid_i & in_ready_o;

  // Resolve advancement from the output end backwards: a stage moves when the
  // one ahead is empty or moving itself, which collapses any bubble.
  always_comb begin
    vacate = '0;
    vacate[DEPTH-1] = stage_valid[DEPTH-1] & out_ready_i;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      vacate[k] = stage_valid[k] & (~stage_valid[k+1] | vacate[k+1]);
    end
  end

  assign stage0_free = ~stage_valid[0] | vacate[0];

`ifdef PIPE_SKID_BUFFER_EN
  logic             skid_valid_d, skid_valid_q;
  logic [WIDTH-1:0] skid_data_d,  skid_data_q;

  // Ready depends only on the skid flop; reset gating keeps it low during reset.
  assign in_ready_o = rst_n_i & ~skid_valid_q;

  // A parked word always feeds stage 0 before anything newer.
  assign stage0_fill = stage0_free & (skid_valid_q | in_fire);
  assign stage0_src  = skid_valid_q ? skid_data_q : in_data_i;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      skid_valid_d = 1'b0;
      skid_data_d  = NOP_VAL;
    end else if (skid_valid_q) begin
      if (stage0_free) begin
        skid_valid_d = 1'b0;
        skid_data_d  = NOP_VAL;
      end
    end else if (in_fire && !stage0_free) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VAL;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Ready follows stage 0 freeing up, which reaches back to out_ready_i.
  assign in_ready_o  = rst_n_i & stage0_free;
  assign stage0_fill = in_fire;
  assign stage0_src  = in_data_i;
`endif

  always_comb begin
    stage_load  = '0;
    stage_clear = '0;
    stage_in[0] = stage0_src;
    stage_load[0] = stage0_fill;
    for (int k = 1; k < int'(DEPTH); k++) begin
      stage_load[k] = vacate[k-1];
      stage_in[k]   = stage_data[k-1];
    end
    // A stage that empties without being refilled drops back to NOP_VAL.
    for (int k = 0; k < int'(DEPTH); k++) begin
      stage_clear[k] = flush_i | (vacate[k] & ~stage_load[k]);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .NOP_VAL (NOP_VAL)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (stage_load[gi]),
      .clear_i (stage_clear[gi]),
      .data_i  (stage_in[gi]),
      .valid_o (stage_valid[gi]),
      .data_o  (stage_data[gi])
    );
  end

  // Words entering the block minus words leaving it; a flush empties it.
  always_comb begin
    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    if (flush_i) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed scenarios followed by random traffic,
// checked against a queue model. Each held word carries a position in the
// chain (-1 = skid entry); every edge it moves one place toward the output
// but never past the slot implied by the number of words ahead of it.
module tb_pipe_reg_chain;
  import pipe_pkg::*;

`ifdef PIPE_SKID_BUFFER_EN
  localparam int DEPTH = 2;
  localparam bit SKID  = 1'b1;
`else
  localparam int DEPTH = 4;
  localparam bit SKID  = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0BAD_F00D;

  logic                          clk_i = 1'b0;
  logic                          rst_n_i = 1'b0;
  logic                          in_valid_i = 1'b0;
  logic                          in_ready_o;
  logic [31:0]                   in_data_i = '0;
  logic                          out_valid_o;
  logic                          out_ready_i = 1'b0;
  logic [31:0]                   out_data_o;
  logic                          flush_i = 1'b0;
  logic [occ_width(DEPTH)-1:0]   occupancy_o;

  pipe_reg_chain #(
    .WIDTH   (32),
    .DEPTH   (DEPTH),
    .NOP_VAL (NOP)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];   // held words, oldest first
  int          mp[$];   // their positions

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() > 0) && (mp[0] == DEPTH - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check ready, take the edge, update the
  // model, then check the registered outputs.
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                      input logic fl, input logic rn);
    bit exp_ir;
    bit pop;
    int n;
    in_valid_i  = iv;
    in_data_i   = id;
    out_ready_i = ordy;
    flush_i     = fl;
    rst_n_i     = rn;
    #1;
    pop = m_out_valid() && ordy;
    n   = mq.size();
    if (!rn) begin
      exp_ir = 1'b0;
    end else if (SKID) begin
      exp_ir = (n == 0) || (mp[n-1] >= 0);
    end else begin
      exp_ir = (n == 0) || (mp[n-1] > 0) || ((n - int'(pop)) <= DEPTH - 1);
    end
    chk("in_ready", 32'(in_ready_o), 32'(exp_ir));
    @(posedge clk_i);
    if (!rn) begin
      mq.delete();
      mp.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        void'(mp.pop_front());
      end
      if (fl) begin
        mq.delete();
        mp.delete();
      end else begin
        for (int j = 0; j < mq.size(); j++) mp[j] = imin(mp[j] + 1, DEPTH - 1 - j);
        if (iv && exp_ir) begin
          n = mq.size();
          mq.push_back(id);
          mp.push_back(imin(0, DEPTH - 1 - n));
        end
      end
    end
    #1;
    chk("out_valid", 32'(out_valid_o), 32'(m_out_valid()));
    chk("out_data", out_data_o, m_out_valid() ? mq[0] : NOP);
    chk("occupancy", 32'(occupancy_o), 32'(mq.size()));
    $display("t=%0t iv=%0b id=%h ordy=%0b fl=%0b rn=%0b -> ov=%0b od=%h occ=%0d",
             $time, iv, id, ordy, fl, rn, out_valid_o, out_data_o, occupancy_o);
  endtask

  initial begin
    // Reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_occ", 32'(occupancy_o), 32'd0);

    // Streaming with downstream always ready
    for (int i = 0; i < 8; i++) step(1'b1, 32'h11 + 32'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure: fill, stall with a word still offered, then drain
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h21 + 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Bubble collapse
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bubble_occ", 32'(occupancy_o), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Flush with a simultaneous input word that must be dropped
    for (int i = 0; i < 3; i++) step(1'b1, 32'h31 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hFF, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream with words held
    step(1'b1, 32'h41, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h42, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
           ($urandom % 32) == 0, ($urandom % 64) != 0);
    end
    for (int i = 0; i < DEPTH + 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
